// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one radix-2 step per cycle,
// shift-add multiply and restoring divide on operand magnitudes, sign fixed at the end.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0]   acc_hi_d, acc_lo_d;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  logic               in_neg, a_neg, b_neg, div0;
  logic [WIDTH-1:0]   a_mag_in, b_mag;
  logic [WIDTH:0]     sum, rem_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  // op[0] = 1 selects the unsigned variants.
  assign in_neg   = ~op[0] & a[WIDTH-1];
  assign a_mag_in = in_neg ? -a : a;
  assign a_neg    = ~op_q[0] & a_q[WIDTH-1];
  assign b_neg    = ~op_q[0] & b_q[WIDTH-1];
  assign b_mag    = b_neg ? -b_q : b_q;
  assign div0     = (b_q == '0);

  always_comb begin
    sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
    rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, b_mag};
    if (op_q[1]) begin
      // Restoring step: keep the trial difference only if it did not borrow.
      if (!diff[WIDTH+1]) begin
        acc_hi_d = diff[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_d = rem_sh[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_d = sum[WIDTH:1];
      acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod     = {acc_hi_d, acc_lo_d};
    prod_fix = (a_neg ^ b_neg) ? -prod : prod;
    quo_fix  = (a_neg ^ b_neg) ? -acc_lo_d : acc_lo_d;
    rem_fix  = a_neg ? -acc_hi_d : acc_hi_d;
    if (op_q[1]) begin
      if (div0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            state_q  <= StCalc;
            op_q     <= op;
            a_q      <= a;
            b_q      <= b;
            acc_hi_q <= '0;
            acc_lo_q <= a_mag_in;
            cnt_q    <= '0;
          end
        end
        StCalc: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              dbz_q   <= op_q[1] & div0;
              state_q <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit (WIDTH = 32): vector table plus random ops checked through a
// result scoreboard, and hand sequences for busy-start, flush, HI writes and reset.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk, rst, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } res_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  res_t         scb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] last_hi;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] mop, input logic [W-1:0] ma,
                                 input logic [W-1:0] mb);
    res_t   r;
    longint p;
    int     sa, sd;
    r.dbz = 1'b0;
    r.hi  = '0;
    r.lo  = '0;
    case (mop)
      2'd0: begin
        p = longint'($signed(ma)) * longint'($signed(mb));
        {r.hi, r.lo} = p;
      end
      2'd1: begin
        p = longint'({32'b0, ma}) * longint'({32'b0, mb});
        {r.hi, r.lo} = p;
      end
      default: begin
        if (mb == '0) begin
          r.hi  = ma;
          r.lo  = '1;
          r.dbz = 1'b1;
        end else if (mop == 2'd2 && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
          r.hi = '0;
          r.lo = 32'h8000_0000;
        end else if (mop == 2'd2) begin
          sa   = $signed(ma);
          sd   = $signed(mb);
          r.lo = sa / sd;
          r.hi = sa % sd;
        end else begin
          r.lo = ma / mb;
          r.hi = ma % mb;
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (scb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        res_t e;
        e = scb.pop_front();
        check("result_hi", hi, e.hi);
        check("result_lo", lo, e.lo);
        check("result_dbz", div_by_zero, e.dbz);
      end
    end
  end

  // Drive one op, wait (bounded) for acceptance, then check done/busy timing.
  task automatic run_op(input logic [1:0] t_op, input logic [W-1:0] t_a,
                        input logic [W-1:0] t_b, input res_t exp, input logic fl,
                        output int edges);
    logic acc;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    start = 1'b1;
    flush = fl;
    scb.push_back(exp);
    last_hi = exp.hi;
    acc   = 1'b0;
    edges = 0;
    for (int i = 0; i < 4 && !acc; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy && !done) acc = 1'b1;
    end
    start = 1'b0;
    flush = 1'b0;
    a     = $urandom;
    b     = $urandom;
    check("accepted", acc, 1);
    if (acc) begin
      repeat (W - 1) @(posedge clk);
      #1;
      check("done_early", done, 0);
      check("busy_calc", busy, 1);
      @(posedge clk);
      #1;
      check("done_rise", done, 1);
      @(posedge clk);
      #1;
      check("done_fall", done, 0);
      check("busy_fall", busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    res_t r;
    int   edges;

    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFFB, 1'b0};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[4] = '{2'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};

    rst = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0; last_hi = '0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      r = '{vecs[i].hi, vecs[i].lo, vecs[i].dbz};
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, (i == 3), edges);
      if (i == 0) check("first_edge_accept", edges, 1);
    end

    for (int i = 0; i < 8; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb), 1'b0, edges);
    end

    // Second start while busy is ignored; HI write while busy is ignored.
    op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    scb.push_back('{32'd0, 32'd12, 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mult_accept", busy, 1);
    repeat (4) @(posedge clk);
    #1;
    a = 32'd100; b = 32'd100; op = 2'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("hi_we_busy", hi, last_hi);
    repeat (26) @(posedge clk);
    #1;
    check("busy_start_done", done, 1);
    @(posedge clk);
    #1;
    check("busy_start_idle", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    hi_we = 1'b1;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("hi_we_idle", hi, 32'hA5A5_A5A5);

    // HI write alongside accepted start, then flush mid-divide.
    op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    check("hi_we_with_start", hi, 32'h1111_1111);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_hi", hi, 32'h1111_1111);
    check("flush_lo", lo, 32'd12);
    run_op(2'd3, 32'd100, 32'd7, '{32'd2, 32'd14, 1'b0}, 1'b0, edges);
    check("after_flush_edges", edges, 1);

    // Asynchronous reset mid-calculation with div_by_zero set beforehand.
    run_op(2'd3, 32'd5, 32'd0, '{32'd5, 32'hFFFF_FFFF, 1'b1}, 1'b0, edges);
    op = 2'd0; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    check("midreset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_idle", busy, 0);
    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0}, 1'b0, edges);
    run_op(2'd2, 32'd9, 32'hFFFF_FFFC, '{32'd1, 32'hFFFF_FFFE, 1'b0}, 1'b0, edges);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", scb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width in bits (even, 8..64).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  WIDTH  multiplicand / dividend.
REQ-007 b  input  WIDTH  multiplier / divisor.
REQ-008 flush  input  1  synchronous abort of an in-flight operation.
REQ-009 hi_we, lo_we  input  1 each  direct write of HI / LO (mthi/mtlo).
REQ-010 wdata  input  WIDTH  data for hi_we / lo_we.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse; HI/LO hold a new result.
REQ-013 div_by_zero  output  1  valid with done; set when a DIV/DIVU had b == 0.
REQ-014 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-015 FSM states: IDLE, CALC, DONE; done = 1 only in DONE; busy = (state != IDLE).
REQ-016 IDLE -> CALC on an edge with start = 1; a, b and op are latched; the iteration counter clears; later changes on a/b/op are ignored.
REQ-017 CALC performs one radix-2 iteration per cycle (shift-add multiply, restoring divide on magnitudes) for exactly WIDTH edges.
REQ-018 On the WIDTH-th CALC edge, the sign-corrected result is written to HI/LO, div_by_zero is updated and the state goes to DONE.
REQ-019 DONE -> IDLE on the next edge, unconditionally.
REQ-020 Latency: with start accepted at edge k, HI/LO update and done rises at edge k+WIDTH; done falls and busy falls at edge k+WIDTH+1; the earliest next accept is edge k+WIDTH+1.
REQ-021 start while busy is ignored; it is neither queued nor flagged.
REQ-022 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product of a*b, two's-complement for MULT.
REQ-023 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero; signed remainder takes the sign of the dividend.
REQ-024 Signed overflow (a = most negative, b = -1): lo = most negative value, hi = 0, div_by_zero = 0.
REQ-025 Divide by zero (DIV or DIVU): same latency; lo = all ones, hi = a, div_by_zero = 1.
REQ-026 div_by_zero holds its value until the next result write; MULT results clear it.
REQ-027 hi_we / lo_we write wdata at the edge only when state is IDLE; they are ignored while busy.
REQ-028 hi_we together with an accepted start in the same IDLE cycle: the write takes effect, and the later result overwrites it.
REQ-029 flush = 1 in CALC or DONE forces IDLE at the next edge; HI/LO and div_by_zero are left unchanged, and done is 0 from that edge.
REQ-030 flush in IDLE has no effect; flush together with start in IDLE means start is accepted.

Reset
REQ-031 rst = 0 immediately forces IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, and clears the counter and operand registers, regardless of the clock.
REQ-032 A reset during CALC or DONE discards the operation; no done pulse follows release.
REQ-033 After rst returns to 1, a start on the first rising edge is accepted.

Verification (WIDTH = 32)
REQ-034 MULT a = 0xFFFFFFFF (-1), b = 0x00000005 -> at edge k+32: hi = 0xFFFFFFFF, lo = 0xFFFFFFFB, done pulse 1 cycle; MULTU with the same operands -> hi = 0x00000004, lo = 0xFFFFFFFB.
REQ-035 DIV a = -7 (0xFFFFFFF9), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1); DIVU a = 7, b = 2 -> lo = 3, hi = 1.
REQ-036 DIVU a = 0x12345678, b = 0 -> lo = 0xFFFFFFFF, hi = 0x12345678, div_by_zero = 1; DIV a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_by_zero = 0.
REQ-037 Start a MULT, pulse start again at k+5 with other operands -> second start ignored, result matches the first; then hi_we with wdata = 0xA5A5A5A5 while busy -> hi unchanged; the same write in IDLE -> hi = 0xA5A5A5A5.
REQ-038 Assert flush at k+10 of a DIV -> busy = 0 at k+11, no done pulse, HI/LO keep prior values; a new start at k+11 completes normally at k+43.
REQ-039 Drive rst low mid-CALC between edges -> outputs zero immediately; after release, no spurious done and back-to-back operations start at edges k and k+33, each with correct results.
